// File: rtl/mac_axis_pkg.sv
// mac_axis_pkg: shared types and constants for the MAC receive AXI-Stream packer.
// Holds the packer state encoding, tuser status bit positions and the byte-lane
// derivation used to size the datapath.
package mac_axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PACK,
        ST_DROP,
        ST_TERM,
        ST_SKIP
    } state_t;

    localparam int TUSER_ERR = 0;
    localparam int TUSER_OVF = 1;

    // Number of byte lanes in a data word of the given bit width.
    function automatic int bytes_of(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/mac_rx_axis_packer_fifo.sv
// axis_sync_fifo: synchronous word FIFO feeding the AXI-Stream master side.
// Read data comes straight from the storage flops; the write side reports
// space that already accounts for a pop happening in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign wr_ready = (count < (AW+1)'(DEPTH)) || pop;
    assign push     = wr_en && wr_ready;
    // Idle output lanes read as zero so nothing stale is visible while tvalid=0.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage write port; contents need no reset because count gates visibility.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_axis_packer.sv
// mac_rx_axis_packer: packs the MAC's byte-wide receive stream little-endian
// into DATA_SIZE-wide AXI-Stream beats. Frame status travels on tuser of the
// tlast beat; FIFO overflow truncates the frame and closes it with an empty
// terminator beat. Define MAC_RX_PACK_STATS_EN to add frame_cnt/drop_cnt.
module mac_rx_axis_packer
    import mac_axis_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int USER_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           rx_dv,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_er,
    output logic                           tvalid,
    output logic [DATA_SIZE-1:0]           tdata,
    output logic [bytes_of(DATA_SIZE)-1:0] tstrb,
    output logic [bytes_of(DATA_SIZE)-1:0] tkeep,
    output logic                           tlast,
    output logic [USER_SIZE-1:0]           tuser,
    input  logic                           tready
`ifdef MAC_RX_PACK_STATS_EN
    ,
    output logic [31:0]                    frame_cnt,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam int BYTES = bytes_of(DATA_SIZE);
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam int ENT_W = DATA_SIZE + BYTES + 3;

    state_t               state;
    logic [DATA_SIZE-1:0] hold;
    logic [CNT_W-1:0]     byte_cnt;
    logic                 err;
    logic                 rst_seen;

    logic [BYTES-1:0]     hold_keep;
    logic                 wr_en;
    logic                 wr_ready;
    logic [DATA_SIZE-1:0] wr_word;
    logic [BYTES-1:0]     wr_keep;
    logic                 wr_last;
    logic [1:0]           wr_user;
    logic [ENT_W-1:0]     wr_data;
    logic                 rd_valid;
    logic [ENT_W-1:0]     rd_data;
    logic [1:0]           rd_user;
    logic                 term_push;

    // Lane mask for the bytes collected so far, contiguous from lane 0.
    always_comb begin
        hold_keep = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            hold_keep[i] = (CNT_W'(i) < byte_cnt);
        end
    end

    // FIFO write request: full word on the next byte, last word or terminator on rx_dv fall.
    always_comb begin
        wr_en   = 1'b0;
        wr_word = hold;
        wr_keep = '1;
        wr_last = 1'b0;
        wr_user = '0;
        unique case (state)
            ST_PACK: begin
                if (rx_dv) begin
                    wr_en = (byte_cnt == CNT_W'(BYTES));
                end else begin
                    wr_en              = 1'b1;
                    wr_keep            = hold_keep;
                    wr_last            = 1'b1;
                    wr_user[TUSER_ERR] = err;
                end
            end
            ST_DROP, ST_TERM: begin
                if (state == ST_TERM || !rx_dv) begin
                    wr_en              = 1'b1;
                    wr_word            = '0;
                    wr_keep            = '0;
                    wr_last            = 1'b1;
                    wr_user[TUSER_ERR] = err;
                    wr_user[TUSER_OVF] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wr_data   = {wr_user, wr_last, wr_keep, wr_word};
    assign term_push = wr_en && wr_ready && (state == ST_DROP || state == ST_TERM);

    // Frame packing state machine; the MAC cannot be stalled so every branch consumes the byte.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= ST_IDLE;
            hold     <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
            rst_seen <= 1'b1;
        end else begin
            rst_seen <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_dv) begin
                        // A frame already in flight when reset released is unaligned: skip it.
                        if (rst_seen) begin
                            state <= ST_SKIP;
                        end else begin
                            state    <= ST_PACK;
                            hold     <= DATA_SIZE'(rx_data);
                            byte_cnt <= CNT_W'(1);
                            err      <= rx_er;
                        end
                    end
                end
                ST_PACK: begin
                    if (rx_dv) begin
                        err <= err | rx_er;
                        if (byte_cnt == CNT_W'(BYTES)) begin
                            if (wr_ready) begin
                                hold     <= DATA_SIZE'(rx_data);
                                byte_cnt <= CNT_W'(1);
                            end else begin
                                state <= ST_DROP;
                            end
                        end else begin
                            for (int unsigned i = 0; i < BYTES; i++) begin
                                if (CNT_W'(i) == byte_cnt) begin
                                    hold[i*8 +: 8] <= rx_data;
                                end
                            end
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= wr_ready ? ST_IDLE : ST_TERM;
                    end
                end
                ST_DROP: begin
                    if (rx_dv) begin
                        err <= err | rx_er;
                    end else begin
                        state <= wr_ready ? ST_IDLE : ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (wr_ready) begin
                        state <= rx_dv ? ST_SKIP : ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (!rx_dv) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (tready)
    );

    assign {rd_user, tlast, tkeep, tdata} = rd_data;
    assign tvalid = rd_valid;
    assign tstrb  = tkeep;
    assign tuser  = USER_SIZE'(rd_user);

`ifdef MAC_RX_PACK_STATS_EN
    logic drop_inc;

    // A frame is dropped when its terminator is queued or when a skipped frame ends.
    assign drop_inc = term_push || (state == ST_SKIP && !rx_dv);

    // Delivered-frame and dropped-frame statistics.
    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (tvalid && tready && tlast) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (drop_inc && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_rx_axis_packer.sv
// tb_mac_rx_axis_packer: directed frames with hand-computed beats pushed to a
// scoreboard queue; a negedge monitor pops and compares on each handshake and
// checks that stalled beats hold steady. Honours MAC_RX_PACK_STATS_EN.
module tb_mac_rx_axis_packer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] user;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic        rx_er;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [31:0] tuser;
    logic        tready;
`ifdef MAC_RX_PACK_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          beat_no = 0;
    bit          tog = 0;
    bit          stalled = 0;
    logic [68:0] held;

    mac_rx_axis_packer #(
        .DATA_SIZE  (32),
        .USER_SIZE  (32),
        .FIFO_DEPTH (4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .rx_dv     (rx_dv),
        .rx_data   (rx_data),
        .rx_er     (rx_er),
        .tvalid    (tvalid),
        .tdata     (tdata),
        .tstrb     (tstrb),
        .tkeep     (tkeep),
        .tlast     (tlast),
        .tuser     (tuser),
        .tready    (tready)
`ifdef MAC_RX_PACK_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Monitor: compare each handshake against the scoreboard, and hold-stability under stall.
    always @(negedge aclk) begin
        exp_t e;
        if (areset) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (!tvalid || {tdata, tkeep, tlast, tuser} != held) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%0b data=%h keep=%h last=%0b user=%h, required valid=1 and held %h",
                             tvalid, tdata, tkeep, tlast, tuser, held);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h keep=%h last=%0b user=%h, required no beat",
                             tdata, tkeep, tlast, tuser);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e.data || tkeep !== e.keep || tstrb !== e.keep ||
                        tlast !== e.last || tuser !== e.user) begin
                        errors++;
                        $display("FAIL beat%0d: got data=%h keep=%h strb=%h last=%0b user=%h, required data=%h keep=%h strb=%h last=%0b user=%h",
                                 beat_no, tdata, tkeep, tstrb, tlast, tuser, e.data, e.keep, e.keep, e.last, e.user);
                    end
                end
                beat_no++;
                stalled = 0;
            end else if (tvalid) begin
                stalled = 1;
                held    = {tdata, tkeep, tlast, tuser};
            end else begin
                stalled = 0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
        if (tog) tready = ~tready;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic [31:0] u);
        exp_t e;
        e.data = d; e.keep = k; e.last = l; e.user = u;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int n, input logic [7:0] start, input int er_at);
        for (int i = 0; i < n; i++) begin
            rx_dv   = 1'b1;
            rx_data = start + 8'(i);
            rx_er   = (i == er_at);
            tick();
        end
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        rx_er   = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (tvalid !== 1'b0 || tdata !== 32'h0 || tkeep !== 4'h0 || tstrb !== 4'h0 ||
            tlast !== 1'b0 || tuser !== 32'h0) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h keep=%h strb=%h last=%0b user=%h, required all 0",
                     name, tvalid, tdata, tkeep, tstrb, tlast, tuser);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        areset  = 1'b1;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        rx_er   = 1'b0;
        tready  = 1'b0;
        repeat (3) tick();
        check_zero("reset_outputs");
`ifdef MAC_RX_PACK_STATS_EN
        check_val("reset_frame_cnt", frame_cnt, 32'd0);
        check_val("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        areset = 1'b0;
        tick();
        tready = 1'b1;

        // 8-byte frame -> two full beats
        expect_beat(32'h04030201, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h08070605, 4'hF, 1'b1, 32'h0);
        send_frame(8, 8'h01, -1);
        drain("frame8");

        // 5-byte frame -> partial last beat
        expect_beat(32'h04030201, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00000005, 4'h1, 1'b1, 32'h0);
        send_frame(5, 8'h01, -1);
        drain("frame5");

        // 6-byte frame with rx_er on byte 3, then a clean one
        expect_beat(32'h04030201, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00000605, 4'h3, 1'b1, 32'h1);
        expect_beat(32'h04030201, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00000605, 4'h3, 1'b1, 32'h0);
        send_frame(6, 8'h01, 2);
        send_frame(6, 8'h01, -1);
        drain("err_then_clean");

        // Overflow: 40 bytes with tready=0 from a fresh reset
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        tready = 1'b0;
        expect_beat(32'h04030201, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h08070605, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h0C0B0A09, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h100F0E0D, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00000000, 4'h0, 1'b1, 32'h2);
        send_frame(40, 8'h01, -1);
        repeat (5) tick();
        tready = 1'b1;
        drain("overflow");
`ifdef MAC_RX_PACK_STATS_EN
        check_val("ovf_frame_cnt", frame_cnt, 32'd1);
        check_val("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Reset pulse at byte 6 of a 12-byte frame; the remainder is skipped
        tready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_dv   = 1'b1;
            rx_data = 8'h10 + 8'(i);
            areset  = (i == 5);
            tick();
            if (i == 5) check_zero("after_midframe_reset");
        end
        areset  = 1'b0;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        tick();
        tready = 1'b1;
        repeat (4) tick();
        expect_beat(32'h24232221, 4'hF, 1'b1, 32'h0);
        send_frame(4, 8'h21, -1);
        drain("post_reset");
`ifdef MAC_RX_PACK_STATS_EN
        check_val("skip_frame_cnt", frame_cnt, 32'd1);
        check_val("skip_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Three back-to-back 7-byte frames with tready toggling every cycle
        expect_beat(32'h34333231, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00373635, 4'h7, 1'b1, 32'h0);
        expect_beat(32'h44434241, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00474645, 4'h7, 1'b1, 32'h0);
        expect_beat(32'h54535251, 4'hF, 1'b0, 32'h0);
        expect_beat(32'h00575655, 4'h7, 1'b1, 32'h0);
        tog = 1;
        send_frame(7, 8'h31, -1);
        send_frame(7, 8'h41, -1);
        send_frame(7, 8'h51, -1);
        tog    = 0;
        tready = 1'b1;
        drain("toggle");
`ifdef MAC_RX_PACK_STATS_EN
        check_val("final_frame_cnt", frame_cnt, 32'd4);
        check_val("final_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        repeat (10) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_rx_axis_packer.md
# mac_rx_axis_packer

Receive-side adapter that converts the MAC's byte-wide, non-stallable receive stream into a DATA_SIZE-wide AXI4-Stream master. It sits directly upstream of the AXI stream slave interface. It packs bytes little-endian and marks frame boundaries with tlast and frame status on tuser. Output backpressure is absorbed by a small word FIFO; on overflow the rest of the frame is discarded and the frame is closed with a null terminator beat.

## Interface

Parameters:
- DATA_SIZE, 32: tdata width; a multiple of 8. BYTES = DATA_SIZE/8.
- USER_SIZE, 32: tuser width; must be at least 2.
- FIFO_DEPTH, 4: output word FIFO depth; a power of 2, at least 2.

Ports:
- aclk, in, 1: clock; all logic samples on the rising edge.
- areset, in, 1: reset; synchronous, active-high.
- rx_dv, in, 1: MAC byte valid; high for the whole frame; at least 1 low cycle between frames.
- rx_data, in, 8: MAC byte.
- rx_er, in, 1: MAC error; meaningful only while rx_dv=1.
- tvalid, out, 1: AXIS valid.
- tdata, out, DATA_SIZE: AXIS data; byte 0 is in [7:0].
- tstrb, out, BYTES: always equal to tkeep.
- tkeep, out, BYTES: valid byte lanes, contiguous from bit 0.
- tlast, out, 1: last beat of the frame.
- tuser, out, USER_SIZE: bit0 = frame error (rx_er seen), bit1 = overflow truncation; other bits are 0. Valid on the tlast beat only; 0 on all other beats.
- tready, in, 1: AXIS ready.
- frame_cnt, out, 32: present only with MAC_RX_PACK_STATS_EN.
- drop_cnt, out, 16: present only with MAC_RX_PACK_STATS_EN.

## Operation

- Bytes fill a hold register at lane = byte index mod BYTES. Unfilled lanes are 0.
- A completed word is written to the FIFO at the edge that samples the next byte (tlast=0), or at the edge that first samples rx_dv=0 (tlast=1). A partial last word is written at that same edge.
- The error flag is sticky per frame. It is set by rx_er=1 with rx_dv=1 and cleared at frame start.
- FIFO "full" accounts for a same-cycle pop. A write succeeds when count<FIFO_DEPTH, or when tvalid&&tready in that cycle.
- State machine:
  - IDLE: rx_dv=1 → PACK, capturing byte 0.
  - PACK: a word write finds the FIFO full → the word is discarded and the state goes to DROP. If rx_dv=0, the last word is written and the state goes to IDLE; if the FIFO is full at that point, go to TERM.
  - DROP: bytes are discarded. On rx_dv=0, push the terminator (tkeep=0, tdata=0, tlast=1, tuser={err,1}) → IDLE; if the FIFO is full → TERM.
  - TERM: push the terminator when space is available, then go to SKIP if rx_dv=1, else IDLE. Bytes arriving while in TERM are discarded.
  - SKIP: discard bytes until rx_dv=0 → IDLE. Each frame discarded this way counts as a drop.
- A frame whose last word cannot be written is handled as an overflow: it is terminated by a terminator beat with tuser[1]=1.
- Beats are emitted in order. No beat is ever reordered or duplicated.

## Timing

- A FIFO write at edge N gives the earliest tvalid=1 in the cycle after N; the FIFO output is registered.
- Last byte of a frame sampled at edge N → tlast beat is written at N+1 → tvalid at the earliest after N+1.
- Sustained throughput is one beat per cycle with tready=1. The MAC is never stalled.
- tvalid, once high, holds tdata, tkeep, tlast and tuser stable until tready=1.
- Reset values: tvalid=0; tdata, tstrb, tkeep, tlast, tuser = 0; FIFO empty; state IDLE; counters 0.
- Reset asserted mid-frame: all contents are lost. If rx_dv=1 in the first cycle after reset release, enter SKIP rather than PACK.

## Configuration

- MAC_RX_PACK_STATS_EN defined:
  - frame_cnt increments on each tlast beat handshake.
  - drop_cnt increments once per frame that receives tuser[1]=1, and once per frame discarded entirely in SKIP.
  - drop_cnt saturates at 0xFFFF; frame_cnt wraps.
- Macro not defined: both ports and all counter logic are absent. Datapath behaviour is identical.

## Structure

- Package mac_axis_pkg holds:
  - the state enum (IDLE, PACK, DROP, TERM, SKIP);
  - the tuser bit indices TUSER_ERR=0 and TUSER_OVF=1;
  - the BYTES derivation helper.
- Sub-module axis_sync_fifo: a parameterized width/depth synchronous FIFO with a registered output and pop-aware full. It carries {tuser bits, tlast, tkeep, tdata}.

## Test plan

Parameters for all scenarios: DATA_SIZE=32, FIFO_DEPTH=4.

- 8-byte frame 0x01..0x08, tready=1 → two beats:
  - beat 1: tdata=0x04030201, tkeep=0xF, tlast=0;
  - beat 2: tdata=0x08070605, tkeep=0xF, tlast=1, tuser=0.
- 5-byte frame 0x01..0x05 → second beat tdata=0x00000005, tkeep=0x1, tstrb=0x1, tlast=1.
- 6-byte frame with rx_er=1 on byte 3 → last beat tuser=0x1. The next clean frame has tuser=0.
- tready=0 during a 40-byte frame, then tready=1 → 4 full beats with tlast=0, then terminator tkeep=0, tlast=1, tuser=0x2. With stats enabled, drop_cnt=1 and frame_cnt=1.
- areset pulse at byte 6 of a 12-byte frame:
  - outputs are 0 in the cycle after reset;
  - the remaining bytes produce no beats;
  - the following 4-byte frame emits one beat, tkeep=0xF, tlast=1.
- Three back-to-back 7-byte frames with 1-cycle gaps and tready toggling every cycle → 6 beats in order, with correct data/tkeep and no drops.
